// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   - div_state_e : FSM state encoding (IDLE, RUN, ZERO, DONE)
//   - clog2()     : iteration counter width helper
//   - DEF_WIDTH / DEF_EXT_W : default operand and quotient widths
package div_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_EXT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Smallest r with 2**r >= value; used to size the iteration counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step (purely combinational).
// Ports:
//   rem_i  [WIDTH:0]   partial remainder from the previous step
//   quo_i  [WIDTH-1:0] shift register: dividend bits not yet consumed (top)
//                      and quotient bits produced so far (bottom)
//   den_i  [WIDTH-1:0] divisor magnitude
//   rem_o  [WIDTH:0]   partial remainder after this step
//   quo_o  [WIDTH-1:0] shift register after this step (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] den_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] den_ext;

  always_comb begin
    // Bring the next dividend bit into the partial remainder. The extra
    // bit keeps the shifted value from overflowing when rem is near den.
    rem_sh  = (rem_i << 1) | {{WIDTH{1'b0}}, quo_i[WIDTH-1]};
    den_ext = {1'b0, den_i};
    if (rem_sh >= den_ext) begin
      rem_o = rem_sh - den_ext;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring integer divider, one quotient bit per clock.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 request, sampled only in IDLE or DONE
//   is_signed             1 = two's-complement operands, captured with start
//   numerator/denominator WIDTH-bit operands, captured with start
//   busy                  high while iterating (RUN)
//   done                  one-cycle pulse when results become valid
//   quotient  [EXT_W-1:0] quotient, sign- or zero-extended per captured mode
//   remainder [WIDTH-1:0] remainder, sign follows numerator in signed mode
//   error                 divide-by-zero flag, held with the results
//
// Handshake: start is taken on a rising edge when the FSM is in IDLE or DONE
// and ignored otherwise. Operands are sampled on that same edge. done is high
// for exactly the one cycle in which new results first appear; results and
// error then hold until the next done (error alone clears on the next
// accepted start).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXT_W = DEF_EXT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [EXT_W-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CNT_W = clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             signed_q, signed_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [EXT_W-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q, error_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  logic             num_neg, den_neg;
  logic [WIDTH-1:0] num_mag, den_mag;
  logic [WIDTH-1:0] rem_mag, q_res, r_res;
  logic [EXT_W-1:0] q_ext;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .den_i (den_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand magnitudes: the core only ever divides non-negative values.
  // The most negative number maps to itself, which is its correct
  // unsigned magnitude.
  assign num_neg = is_signed & numerator[WIDTH-1];
  assign den_neg = is_signed & denominator[WIDTH-1];
  assign num_mag = num_neg ? -numerator : numerator;
  assign den_mag = den_neg ? -denominator : denominator;

  // Final sign fix-up uses the last step's outputs so results land in the
  // same edge that enters DONE.
  assign rem_mag = step_rem[WIDTH-1:0];
  assign q_res   = neg_q_q ? -step_quo : step_quo;
  assign r_res   = neg_r_q ? -rem_mag : rem_mag;

  always_comb begin
    q_ext = {EXT_W{signed_q & q_res[WIDTH-1]}};
    q_ext[WIDTH-1:0] = q_res;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    den_d       = den_q;
    signed_d    = signed_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          error_d  = 1'b0;
          signed_d = is_signed;
          cnt_d    = '0;
          rem_d    = '0;
          if (denominator == '0) begin
            // Raw numerator is parked in quo so ZERO can return it verbatim.
            state_d = ST_ZERO;
            quo_d   = numerator;
            den_d   = '0;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
          end else begin
            state_d = ST_RUN;
            quo_d   = num_mag;
            den_d   = den_mag;
            neg_q_d = num_neg ^ den_neg;
            neg_r_d = num_neg;
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = q_ext;
          remainder_d = r_res;
          error_d     = 1'b0;
        end
      end
      ST_ZERO: begin
        state_d     = ST_DONE;
        quotient_d  = '1;
        remainder_d = quo_q;
        error_d     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      signed_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      den_q       <= den_d;
      signed_q    <= signed_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign error     = error_q;

endmodule
